// File: rtl/axi_lite_uart_if.sv
// AXI4-Lite register bus between a master and the UART register block.
// No logic, wires only: latency is whatever the two endpoints implement.
// Backpressure: standard valid/ready on AW, W, B, AR and R channels.
interface axi_lite_uart_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_uart.sv
// AXI-Lite UART: TX FIFO feeding an 8N1 serialiser, single-byte RX holding register.
// Latency: B/R one cycle after handshake; TXDATA write into idle UART puts start bit on tx two cycles later.
// Backpressure: one outstanding write and read; full TX FIFO drops data and answers SLVERR.
module axi_lite_uart #(
    parameter int CLK_DIV       = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_lite_uart_if.slave  axi,
    output logic            tx,
    input  logic            rx
);
    localparam int          AW       = $clog2(TX_FIFO_DEPTH);
    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1  = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] CNT_INC  = 16'd1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   OCC_ONE = 1;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(TX_FIFO_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CLEAR   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // ---------------------------------------------------------------- bus side
    logic        b_vld;
    logic [1:0]  b_resp;
    logic        r_vld;
    logic [31:0] r_dat;
    logic        wr_hs;
    logic        rd_hs;
    logic [1:0]  wr_reg;
    logic [1:0]  rd_reg;
    logic [31:0] rd_mux;
    logic [31:0] status;

    // address bits outside [3:2], wstrb and upper wdata carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{axi.awaddr[63:4], axi.awaddr[1:0], axi.araddr[63:4],
                           axi.araddr[1:0], axi.wdata[31:8], axi.wstrb};

    assign wr_reg = axi.awaddr[3:2];
    assign rd_reg = axi.araddr[3:2];

    // write accepted only with address and data together and no B pending
    assign wr_hs       = rst_n & axi.awvalid & axi.wvalid & ~b_vld;
    assign axi.awready = wr_hs;
    assign axi.wready  = wr_hs;
    assign axi.arready = rst_n & ~r_vld;
    assign rd_hs       = axi.arvalid & axi.arready;

    assign axi.bvalid = b_vld;
    assign axi.bresp  = b_resp;
    assign axi.rvalid = r_vld;
    assign axi.rdata  = r_dat;
    assign axi.rresp  = RESP_OKAY;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_head;

    assign fifo_full  = (fifo_cnt == OCC_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[rd_ptr];
    // full is judged on the pre-edge occupancy, so a same-cycle pop never makes room
    assign push       = wr_hs & (wr_reg == REG_TXDATA) & ~fifo_full;

    // FIFO storage, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= axi.wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OCC_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - OCC_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------------- TX serialiser
    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_busy;

    assign tx_busy = (tx_state != S_IDLE);
    // pull the next byte when idle, or at the last stop cycle for gapless frames
    assign pop = ~fifo_empty &
                 ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_cnt == DIV_M1)));

    // TX FSM; tx is a flop so the line never glitches between states
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (pop) begin
                        tx_shift <= fifo_head;
                        tx       <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_INC;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx       <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_INC;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt <= '0;
                        if (pop) begin
                            tx_shift <= fifo_head;
                            tx       <= 1'b0;
                            tx_state <= S_START;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_INC;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX path
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_fall;
    uart_state_t rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_end;
    logic        rx_done_ok;
    logic        rx_frame_err;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        overrun;
    logic        framing_err;
    logic        rd_rx;
    logic        clr_hs;
    logic        ovr_set;

    // two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall      = rx_prev & ~rx_sync;
    assign rx_stop_end  = (rx_state == S_STOP) & (rx_cnt == DIV_M1);
    assign rx_done_ok   = rx_stop_end & rx_sync;
    assign rx_frame_err = rx_stop_end & ~rx_sync;

    // RX FSM: half a bit to the start centre, then one full bit per sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_INC;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_INC;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_INC;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    assign rd_rx   = rd_hs & (rd_reg == REG_RXDATA);
    assign clr_hs  = wr_hs & (wr_reg == REG_CLEAR);
    // a read in the completion cycle frees the holder, so that is not an overrun
    assign ovr_set = rx_done_ok & rx_valid & ~rd_rx;

    // RX holding register and sticky flags; a new error beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid    <= 1'b0;
            rx_byte     <= '0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (rx_done_ok && (!rx_valid || rd_rx)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            overrun     <= ovr_set | (overrun & ~(clr_hs & axi.wdata[3]));
            framing_err <= rx_frame_err | (framing_err & ~(clr_hs & axi.wdata[4]));
        end
    end

    // ---------------------------------------------------------------- responses
    assign status = {26'b0, tx_busy, framing_err, overrun, rx_valid, fifo_empty, fifo_full};

    // read data mux; write-only registers read back as zero
    always_comb begin
        rd_mux = '0;
        case (rd_reg)
            REG_RXDATA: rd_mux = {rx_valid, 23'b0, rx_byte};
            REG_STATUS: rd_mux = status;
            default:    rd_mux = '0;
        endcase
    end

    // write response: SLVERR only for a TXDATA write that found the FIFO full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_vld  <= 1'b0;
            b_resp <= RESP_OKAY;
        end else if (wr_hs) begin
            b_vld  <= 1'b1;
            b_resp <= ((wr_reg == REG_TXDATA) && fifo_full) ? RESP_SLVERR : RESP_OKAY;
        end else if (b_vld && axi.bready) begin
            b_vld <= 1'b0;
        end
    end

    // read response captured at the handshake and held until rready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (rd_hs) begin
            r_vld <= 1'b1;
            r_dat <= rd_mux;
        end else if (r_vld && axi.rready) begin
            r_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_uart.sv
// Directed bench for axi_lite_uart: three instances at CLK_DIV 4, 16 and 8 share one
// bus master; sel picks which instance sees valid strobes and drives the response view.
module tb_axi_lite_uart;
    logic clk;
    logic rst_n;
    logic rx_line;
    logic tx_a, tx_b, tx_c;
    int   sel;
    int   cyc;
    int   n_pass;
    int   n_checks;
    logic tx_hist [0:4095];

    logic [63:0] m_awaddr, m_araddr;
    logic [31:0] m_wdata;
    logic        m_awvalid, m_wvalid, m_arvalid;

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp;
    logic [31:0] s_rdata;

    axi_lite_uart_if ifa ();
    axi_lite_uart_if ifb ();
    axi_lite_uart_if ifc ();

    axi_lite_uart #(.CLK_DIV(4),  .TX_FIFO_DEPTH(8)) u_a (.clk(clk), .rst_n(rst_n), .axi(ifa), .tx(tx_a), .rx(rx_line));
    axi_lite_uart #(.CLK_DIV(16), .TX_FIFO_DEPTH(8)) u_b (.clk(clk), .rst_n(rst_n), .axi(ifb), .tx(tx_b), .rx(rx_line));
    axi_lite_uart #(.CLK_DIV(8),  .TX_FIFO_DEPTH(8)) u_c (.clk(clk), .rst_n(rst_n), .axi(ifc), .tx(tx_c), .rx(rx_line));

    assign ifa.awaddr = m_awaddr; assign ifa.wdata = m_wdata; assign ifa.wstrb = 4'hF;
    assign ifa.araddr = m_araddr; assign ifa.bready = 1'b1;   assign ifa.rready = 1'b1;
    assign ifa.awvalid = m_awvalid && sel == 0; assign ifa.wvalid = m_wvalid && sel == 0;
    assign ifa.arvalid = m_arvalid && sel == 0;
    assign ifb.awaddr = m_awaddr; assign ifb.wdata = m_wdata; assign ifb.wstrb = 4'hF;
    assign ifb.araddr = m_araddr; assign ifb.bready = 1'b1;   assign ifb.rready = 1'b1;
    assign ifb.awvalid = m_awvalid && sel == 1; assign ifb.wvalid = m_wvalid && sel == 1;
    assign ifb.arvalid = m_arvalid && sel == 1;
    assign ifc.awaddr = m_awaddr; assign ifc.wdata = m_wdata; assign ifc.wstrb = 4'hF;
    assign ifc.araddr = m_araddr; assign ifc.bready = 1'b1;   assign ifc.rready = 1'b1;
    assign ifc.awvalid = m_awvalid && sel == 2; assign ifc.wvalid = m_wvalid && sel == 2;
    assign ifc.arvalid = m_arvalid && sel == 2;

    always_comb begin
        case (sel)
            0: begin
                s_awready = ifa.awready; s_wready = ifa.wready; s_bvalid = ifa.bvalid; s_bresp = ifa.bresp;
                s_arready = ifa.arready; s_rvalid = ifa.rvalid; s_rdata = ifa.rdata;
            end
            1: begin
                s_awready = ifb.awready; s_wready = ifb.wready; s_bvalid = ifb.bvalid; s_bresp = ifb.bresp;
                s_arready = ifb.arready; s_rvalid = ifb.rvalid; s_rdata = ifb.rdata;
            end
            default: begin
                s_awready = ifc.awready; s_wready = ifc.wready; s_bvalid = ifc.bvalid; s_bresp = ifc.bresp;
                s_arready = ifc.arready; s_rvalid = ifc.rvalid; s_rdata = ifc.rdata;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // record the 16-divider instance's line so whole frame trains can be checked afterwards
    always @(negedge clk) if (cyc < 4096) tx_hist[cyc] <= tx_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // call at a negedge; returns at the negedge of the cycle after the handshake
    task automatic axi_write(input logic [63:0] addr, input logic [31:0] data,
                             output logic [1:0] resp, output int hs_cyc);
        bit got;
        got = 1'b0;
        m_awaddr = addr; m_wdata = data; m_awvalid = 1'b1; m_wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_awready && s_wready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        hs_cyc = cyc;
        if (got) @(posedge clk);
        #1 m_awvalid = 1'b0; m_wvalid = 1'b0;
        chk("aw_w_handshake", got, 1);
        @(negedge clk);
        chk("bvalid_next_cycle", s_bvalid, 1);
        resp = s_bresp;
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [31:0] data);
        bit got;
        got = 1'b0;
        m_araddr = addr; m_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_arready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (got) @(posedge clk);
        #1 m_arvalid = 1'b0;
        chk("ar_handshake", got, 1);
        @(negedge clk);
        chk("rvalid_next_cycle", s_rvalid, 1);
        data = s_rdata;
    endtask

    // 8N1 frame at 8 clocks per bit, then a short idle gap
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_line = 1'b0;
        repeat (8) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rx_line = d[j];
            repeat (8) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (8) @(negedge clk);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [9:0]  frame;
        logic [7:0]  byte_v;
        int          hs, hs0, target;

        n_pass = 0; n_checks = 0; sel = 2;
        rst_n = 1'b0; rx_line = 1'b1;
        m_awaddr = '0; m_araddr = '0; m_wdata = '0;
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_tx_a", tx_a, 1);
        chk("reset_tx_b", tx_b, 1);
        chk("reset_tx_c", tx_c, 1);
        chk("reset_bvalid", s_bvalid, 0);
        chk("reset_rvalid", s_rvalid, 0);
        chk("reset_arready", s_arready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(64'h8, rd);                       chk("status_after_reset", rd, 32'h02);
        axi_read(64'hFFFF_FFFF_0000_0018, rd);     chk("status_high_addr", rd, 32'h02);
        axi_read(64'h0, rd);                       chk("txdata_reads_zero", rd, 32'h0);
        axi_read(64'hC, rd);                       chk("clear_reads_zero", rd, 32'h0);
        axi_write(64'h8, 32'hFF, resp, hs);        chk("status_write_okay", resp, 2'b00);

        // single byte 0xA5 at 4 clocks per bit
        sel = 0;
        @(negedge clk);
        axi_write(64'h0, 32'h0000_01A5, resp, hs);
        chk("tx_single_bresp", resp, 2'b00);
        chk("tx_high_at_n1", tx_a, 1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("tx_a5_cyc%0d", k), tx_a, frame[k / 4]);
        end
        @(negedge clk);
        chk("tx_idle_after_stop", tx_a, 1);
        axi_read(64'h8, rd);                       chk("status_after_tx", rd, 32'h02);

        // overflow: ten writes, one popped, eight queued, tenth rejected
        sel = 1;
        hs0 = 0;
        for (int i = 0; i < 10; i++) begin
            byte_v = 8'h81 + 8'(i) * 8'h11;
            axi_write(64'hFFFF_0000_0000_0010, {24'hABCDEF, byte_v}, resp, hs);
            if (i == 0) hs0 = hs;
            chk($sformatf("ovf_bresp_%0d", i), resp, (i < 9) ? 2'b00 : 2'b10);
        end
        axi_read(64'h8, rd);                       chk("status_full_busy", rd, 32'h21);
        target = hs0 + 2 + 90 * 16 + 4;
        while (cyc < target) @(negedge clk);
        for (int f = 0; f < 9; f++) begin
            byte_v = 8'h81 + 8'(f) * 8'h11;
            frame = {1'b1, byte_v, 1'b0};
            for (int j = 0; j < 10; j++) begin
                target = hs0 + 2 + (f * 10 + j) * 16 + 8;
                chk($sformatf("ovf_frame%0d_bit%0d", f, j), tx_hist[target], frame[j]);
            end
        end
        axi_read(64'h8, rd);                       chk("status_after_train", rd, 32'h02);

        // receive 0x3C at 8 clocks per bit
        sel = 2;
        send_frame(8'h3C, 1'b1);
        axi_read(64'h8, rd);                       chk("rx_status_valid", rd, 32'h06);
        axi_read(64'h4, rd);                       chk("rxdata_first", rd, 32'h8000_003C);
        axi_read(64'h4, rd);                       chk("rxdata_second", rd, 32'h0000_003C);

        // overrun, framing error, clear
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        axi_read(64'h8, rd);                       chk("status_overrun", rd, 32'h0E);
        axi_read(64'h4, rd);                       chk("rxdata_kept_first", rd, 32'h8000_0011);
        send_frame(8'h55, 1'b0);
        axi_read(64'h8, rd);                       chk("status_framing", rd, 32'h1A);
        axi_write(64'hC, 32'h18, resp, hs);        chk("clear_bresp", resp, 2'b00);
        axi_read(64'h8, rd);                       chk("status_cleared", rd, 32'h02);

        // two-cycle glitch on rx must be rejected silently
        rx_line = 1'b0;
        repeat (2) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        axi_read(64'h8, rd);                       chk("status_after_glitch", rd, 32'h02);

        // reset in the middle of a TX frame with a second byte queued
        sel = 0;
        axi_write(64'h0, 32'h00, resp, hs);        chk("pre_reset_bresp0", resp, 2'b00);
        axi_write(64'h0, 32'h00, resp, hs);        chk("pre_reset_bresp1", resp, 2'b00);
        repeat (8) @(negedge clk);
        chk("tx_low_mid_frame", tx_a, 0);
        m_awaddr = 64'h0; m_awvalid = 1'b1; m_wvalid = 1'b1; m_arvalid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_tx_high", tx_a, 1);
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(64'h8, rd);                       chk("status_after_midreset", rd, 32'h02);
        chk("tx_idle_after_midreset", tx_a, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_uart.md
AXI_LITE_UART -- requirements
Module: axi_lite_uart

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868: clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 8: TX FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port axi, AXI_LITE slave modport, ADDR 64 / DATA 32: register access.
REQ-006 SHALL have port tx, output, 1 bit: serial output, 8N1 format, idle high.
REQ-007 SHALL have port rx, input, 1 bit: serial input, asynchronous to clk.

Function
REQ-008 SHALL decode registers on axi addr[3:2] and ignore all other address bits.
- 0: TXDATA (W).
- 1: RXDATA (R).
- 2: STATUS (R).
- 3: CLEAR (W1C).
REQ-009 SHALL support one outstanding write and one outstanding read.
- Accept a write only when AW and W are both valid; drive awready and wready high in the same cycle.
- Drive bvalid the next cycle and hold it until bready.
REQ-010 SHALL, on a read handshake at cycle N, drive rvalid with rdata at N+1 and hold both until rready.
REQ-011 SHALL return resp OKAY on every access except the REQ-012 case; reads of write-only registers return 0.
REQ-012 SHALL handle a TXDATA write when the FIFO is full as follows: drop the data and return bresp SLVERR.
- Full is evaluated in the handshake cycle.
- A same-cycle pop does not create room.
REQ-013 SHALL push wdata[7:0] on an accepted TXDATA write; wstrb is ignored.
REQ-014 SHALL run the TX FSM IDLE -> START -> DATA -> STOP -> IDLE.
- Each state bit lasts exactly CLK_DIV cycles.
- DATA sends bits LSB first over 8 bits.
- STOP drives tx = 1.
REQ-015 SHALL, for a write handshake at cycle N into an empty FIFO with the FSM idle, push at N, pop at N+1, and drive tx low from N+2.
REQ-016 SHALL go from STOP directly to START, with no idle gap, when the FIFO is non-empty at the end of STOP.
REQ-017 SHALL register tx (glitch-free).
REQ-018 SHALL synchronise rx through 2 flops before any use.
REQ-019 SHALL run the RX FSM IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE -> START on a synchronised falling edge.
- START samples at CLK_DIV/2; a high sample returns to IDLE (glitch reject, no flags).
- DATA samples each bit at its centre.
REQ-020 SHALL handle an RX stop-bit sample of 0 as follows: set framing_err (sticky) and discard the byte.
REQ-021 SHALL handle a valid stop bit as follows:
- If rx_valid = 0: load the byte into the single RX holding register and set rx_valid.
- If rx_valid = 1: discard the new byte and set overrun (sticky).
REQ-022 SHALL, on a read of RXDATA, return rdata = {rx_valid, 23'b0, rx_byte} and clear rx_valid at the read handshake.
REQ-023 SHALL handle an RX completion in the same cycle as an RXDATA read handshake as follows:
- The read returns the old byte.
- The new byte loads.
- rx_valid stays 1.
- overrun is not set.
REQ-024 SHALL return STATUS as: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 overrun, bit4 framing_err, bit5 tx_busy (FSM not IDLE), other bits 0.
REQ-025 SHALL, on a CLEAR write, clear overrun for wdata[3] = 1 and framing_err for wdata[4] = 1; a same-cycle new error wins (flag stays set).
REQ-026 SHALL handle a simultaneous FIFO push and pop when not full as follows: both take effect and the occupancy is unchanged.

Reset
REQ-027 SHALL, while rst_n is low at a clk edge, clear all state: FIFO empty, both FSMs IDLE, rx_valid 0, overrun 0, framing_err 0.
REQ-028 SHALL hold these outputs during reset: tx = 1, awready = wready = arready = 0, bvalid = rvalid = 0.
REQ-029 SHALL, on reset mid-frame, drive tx = 1 from the first reset edge; a partially received RX byte is lost with no flag.
REQ-030 SHALL resume accepting handshakes on the first clk edge after rst_n returns high.

Verification
REQ-031 SHALL cover TX single byte with CLK_DIV=4: write TXDATA 0xA5 at cycle N -> tx low N+2..N+5, then bits 1,0,1,0,0,1,0,1, then high for 4 cycles; bresp OKAY.
REQ-032 SHALL cover TX overflow, depth 8, CLK_DIV=16: 10 back-to-back writes -> tx_busy=1, first 9 OKAY (1 popped into FSM), 10th SLVERR; 9 frames sent back-to-back with no gaps.
REQ-033 SHALL cover RX: drive frame 0x3C at CLK_DIV=8 -> STATUS bit2 = 1; RXDATA read returns 0x8000003C; the next read returns 0x0000003C with bit31 = 0.
REQ-034 SHALL cover RX errors: a 2nd frame without reading -> overrun=1 and the 1st byte kept; a frame with stop=0 -> framing_err=1; CLEAR wdata 0x18 -> both 0.
REQ-035 SHALL cover glitch and reset: a 2-cycle low pulse on rx -> no rx_valid and no flags; rst_n low mid-TX-frame -> tx = 1 next cycle, STATUS = 0x02 after release.
